// File: rtl/jt900h_busctl_pkg.sv
// Shared definitions for the jt900h bus bridge: widths, region indices,
// bridge states and the latched external request.
package jt900h_busctl_pkg;

  localparam int unsigned AW     = 24;
  localparam int unsigned BAW    = 23;
  localparam int unsigned DW     = 16;
  localparam int unsigned WCNT_W = 4;
  localparam int unsigned TCNT_W = 8;

  localparam int unsigned CS_ROM = 0;
  localparam int unsigned CS_RAM = 1;
  localparam int unsigned CS_IO  = 2;

  typedef enum logic [1:0] {
    BUS_IDLE,
    BUS_WAIT,
    BUS_ACK,
    BUS_DONE
  } bus_state_t;

  typedef struct packed {
    logic [BAW-1:0] addr;
    logic [DW-1:0]  data;
    logic [1:0]     we;
    logic [2:0]     cs;
  } bus_req_t;

endpackage

// File: rtl/jt900h_busdec.sv
// Combinational address decoder: byte address to one-hot region select
// plus that region's wait-state count.
module jt900h_busdec
  import jt900h_busctl_pkg::*;
#(
  parameter logic [AW-1:0] IO_END    = 24'h000100,
  parameter logic [AW-1:0] ROM_START = 24'h200000,
  parameter int unsigned   WAIT_IO   = 2,
  parameter int unsigned   WAIT_RAM  = 0,
  parameter int unsigned   WAIT_ROM  = 1
)(
  input  logic [AW-1:0]     addr,
  output logic [2:0]        cs,
  output logic [WCNT_W-1:0] wait_cnt
);

  always_comb begin
    cs       = '0;
    wait_cnt = '0;
    if (addr >= ROM_START) begin
      cs[CS_ROM] = 1'b1;
      wait_cnt   = WCNT_W'(WAIT_ROM);
    end else if (addr < IO_END) begin
      cs[CS_IO]  = 1'b1;
      wait_cnt   = WCNT_W'(WAIT_IO);
    end else begin
      cs[CS_RAM] = 1'b1;
      wait_cnt   = WCNT_W'(WAIT_RAM);
    end
  end

endmodule

// File: rtl/jt900h_busctl.sv
// Bus bridge behind the CPU RAM controller: decodes regions, inserts wait
// states, waits for bus_ok and stalls the CPU via cpu_cen until done.
module jt900h_busctl
  import jt900h_busctl_pkg::*;
#(
  parameter logic [AW-1:0] IO_END    = 24'h000100,
  parameter logic [AW-1:0] ROM_START = 24'h200000,
  parameter int unsigned   WAIT_IO   = 2,
  parameter int unsigned   WAIT_RAM  = 0,
  parameter int unsigned   WAIT_ROM  = 1,
  parameter int unsigned   TOUT      = 255
)(
  input  logic           clk,
  input  logic           rst,
  input  logic           cen,
  output logic           cpu_cen,
  input  logic [AW-1:0]  ram_addr,
  input  logic [DW-1:0]  ram_din,
  input  logic [1:0]     ram_we,
  output logic [DW-1:0]  ram_dout,
  output logic [BAW-1:0] bus_addr,
  output logic [DW-1:0]  bus_dout,
  output logic [1:0]     bus_we,
  output logic [2:0]     bus_cs,
  input  logic [DW-1:0]  bus_din,
  input  logic           bus_ok,
  output logic           bus_err
);

  bus_state_t        state, state_nxt;
  bus_req_t          req, req_nxt;
  logic [DW-1:0]     dout_q, dout_nxt;
  logic              err_q, err_nxt;
  logic [BAW-1:0]    last_addr, last_nxt;
  logic              valid, valid_nxt;
  logic [WCNT_W-1:0] wcnt, wcnt_nxt;
  logic [TCNT_W-1:0] tcnt, tcnt_nxt;
  logic              is_wr, is_wr_nxt;
  logic              is_rom, is_rom_nxt;
  logic              rel, rel_nxt;
  logic [2:0]        dec_cs;
  logic [WCNT_W-1:0] dec_wait;
  logic              new_req_c;

  jt900h_busdec #(
    .IO_END   (IO_END),
    .ROM_START(ROM_START),
    .WAIT_IO  (WAIT_IO),
    .WAIT_RAM (WAIT_RAM),
    .WAIT_ROM (WAIT_ROM)
  ) u_dec (
    .addr    (ram_addr),
    .cs      (dec_cs),
    .wait_cnt(dec_wait)
  );

  // rel marks the IDLE cycle right after DONE: that cycle belongs to the
  // controller so a held write or refetch cannot retrigger itself.
  assign new_req_c = (state == BUS_IDLE) && !rel &&
                     ((ram_we != 2'b00) || !valid || (ram_addr[AW-1:1] != last_addr));
  assign cpu_cen   = cen & ~(new_req_c | (state != BUS_IDLE));

  assign ram_dout = dout_q;
  assign bus_addr = req.addr;
  assign bus_dout = req.data;
  assign bus_we   = req.we;
  assign bus_cs   = req.cs;
  assign bus_err  = err_q;

  always_comb begin
    state_nxt  = state;
    req_nxt    = req;
    dout_nxt   = dout_q;
    err_nxt    = err_q;
    last_nxt   = last_addr;
    valid_nxt  = valid;
    wcnt_nxt   = wcnt;
    tcnt_nxt   = tcnt;
    is_wr_nxt  = is_wr;
    is_rom_nxt = is_rom;
    rel_nxt    = rel;
    case (state)
      BUS_IDLE: begin
        rel_nxt = 1'b0;
        if (new_req_c) begin
          state_nxt    = BUS_WAIT;
          req_nxt.addr = ram_addr[AW-1:1];
          req_nxt.data = ram_din;
          req_nxt.cs   = dec_cs;
          req_nxt.we   = dec_cs[CS_ROM] ? 2'b00 : ram_we;
          wcnt_nxt     = dec_wait;
          tcnt_nxt     = '0;
          is_wr_nxt    = (ram_we != 2'b00);
          is_rom_nxt   = dec_cs[CS_ROM];
        end
      end
      BUS_WAIT: begin
        if (wcnt == '0) state_nxt = BUS_ACK;
        else            wcnt_nxt  = wcnt - WCNT_W'(1);
      end
      BUS_ACK: begin
        // ROM writes have no target, so they never wait for bus_ok
        if (bus_ok || (is_wr && is_rom)) begin
          if (!is_wr) dout_nxt = bus_din;
          last_nxt   = req.addr;
          valid_nxt  = !is_wr;
          req_nxt.cs = '0;
          req_nxt.we = '0;
          state_nxt  = BUS_DONE;
        end else if (tcnt == TCNT_W'(TOUT)) begin
          if (!is_wr) dout_nxt = '1;
          err_nxt    = 1'b1;
          valid_nxt  = 1'b0;
          req_nxt.cs = '0;
          req_nxt.we = '0;
          state_nxt  = BUS_DONE;
        end else begin
          tcnt_nxt = tcnt + TCNT_W'(1);
        end
      end
      BUS_DONE: begin
        rel_nxt   = 1'b1;
        state_nxt = BUS_IDLE;
      end
      default: state_nxt = BUS_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= BUS_IDLE;
      req       <= '0;
      dout_q    <= '0;
      err_q     <= 1'b0;
      last_addr <= '0;
      valid     <= 1'b0;
      wcnt      <= '0;
      tcnt      <= '0;
      is_wr     <= 1'b0;
      is_rom    <= 1'b0;
      rel       <= 1'b0;
    end else if (cen) begin
      state     <= state_nxt;
      req       <= req_nxt;
      dout_q    <= dout_nxt;
      err_q     <= err_nxt;
      last_addr <= last_nxt;
      valid     <= valid_nxt;
      wcnt      <= wcnt_nxt;
      tcnt      <= tcnt_nxt;
      is_wr     <= is_wr_nxt;
      is_rom    <= is_rom_nxt;
      rel       <= rel_nxt;
    end
  end

endmodule

// File: tb/tb_jt900h_busctl.sv
// Table-driven bench for jt900h_busctl: each vector is one CPU access whose
// expected outcome goes through a scoreboard queue until the stall ends.
module tb_jt900h_busctl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cen;
  logic        cpu_cen;
  logic [23:0] ram_addr;
  logic [15:0] ram_din;
  logic [1:0]  ram_we;
  logic [15:0] ram_dout;
  logic [22:0] bus_addr;
  logic [15:0] bus_dout;
  logic [1:0]  bus_we;
  logic [2:0]  bus_cs;
  logic [15:0] bus_din;
  logic        bus_ok;
  logic        bus_err;

  jt900h_busctl dut (
    .clk(clk), .rst(rst), .cen(cen), .cpu_cen(cpu_cen),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout),
    .bus_addr(bus_addr), .bus_dout(bus_dout), .bus_we(bus_we), .bus_cs(bus_cs),
    .bus_din(bus_din), .bus_ok(bus_ok), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] addr;
    logic [1:0]  we;
    logic [15:0] din;
    logic [15:0] bdin;
    int          ok_dly;  // cen cycles of bus_cs before bus_ok rises
    bit          tog;     // toggle cen every cycle
    bit          newcyc;  // a bus cycle is expected
    logic [2:0]  cs;
    logic [22:0] baddr;
    logic [1:0]  bwe;
    int          stall;   // cen cycles stalled after the request is taken
    logic [15:0] rdata;
    logic        err;
  } vec_t;

  vec_t vecs[13];
  vec_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(logic [23:0] addr, logic [1:0] we, logic [15:0] din,
                              logic [15:0] bdin, int ok_dly, bit tog, bit newcyc,
                              logic [2:0] cs, logic [22:0] baddr, logic [1:0] bwe,
                              int stall, logic [15:0] rdata, logic err);
    vec_t v;
    v.addr = addr; v.we = we; v.din = din; v.bdin = bdin; v.ok_dly = ok_dly;
    v.tog = tog; v.newcyc = newcyc; v.cs = cs; v.baddr = baddr; v.bwe = bwe;
    v.stall = stall; v.rdata = rdata; v.err = err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    vec_t e;
    int   lowcnt = 0;
    int   cs_seen = 0;
    int   cyc = 0;
    bit   done = 1'b0;
    bit   bad = 1'b0;
    sb.push_back(v);
    @(posedge clk); #1;
    ram_addr = v.addr; ram_we = v.we; ram_din = v.din;
    bus_din = v.bdin; cen = 1'b1; bus_ok = (v.ok_dly == 0);
    while (!done && cyc < 600) begin
      @(negedge clk);
      if (bus_cs != 3'b000 &&
          (bus_cs !== v.cs || bus_addr !== v.baddr || bus_we !== v.bwe || bus_dout !== v.din))
        bad = 1'b1;
      if (cen) begin
        if (cpu_cen) done = 1'b1;
        else lowcnt++;
        if (bus_cs != 3'b000) cs_seen++;
      end
      if (!done) begin
        @(posedge clk); #1;
        cyc++;
        cen    = v.tog ? ~cen : 1'b1;
        bus_ok = (cs_seen >= v.ok_dly);
      end
    end
    e = sb.pop_front();
    if (!done) begin
      checks++; errors++;
      $display("FAIL v%0d_timeout act=stalled exp=cpu_cen_release", idx);
    end
    chk($sformatf("v%0d_stall", idx), (lowcnt == 0) ? 0 : lowcnt - 1, e.stall);
    chk($sformatf("v%0d_newcyc", idx), 32'(cs_seen != 0), 32'(e.newcyc));
    chk($sformatf("v%0d_bus_held", idx), 32'(bad), 0);
    chk($sformatf("v%0d_cs_drop", idx), 32'(bus_cs), 0);
    chk($sformatf("v%0d_rdata", idx), 32'(ram_dout), 32'(e.rdata));
    chk($sformatf("v%0d_err", idx), 32'(bus_err), 32'(e.err));
  endtask

  initial begin
    //           addr      we     din      bdin     dly  tog new cs      baddr      bwe    stall rdata    err
    vecs[0]  = mk(24'h001234, 2'b00, 16'h0000, 16'hBEEF, 0,    0, 1, 3'b010, 23'h00091A, 2'b00, 3,   16'hBEEF, 0);
    vecs[1]  = mk(24'h001235, 2'b00, 16'h0000, 16'h0000, 0,    0, 0, 3'b000, 23'h000000, 2'b00, 0,   16'hBEEF, 0);
    vecs[2]  = mk(24'h000010, 2'b01, 16'h00A5, 16'h0000, 0,    0, 1, 3'b100, 23'h000008, 2'b01, 5,   16'hBEEF, 0);
    vecs[3]  = mk(24'h000010, 2'b00, 16'h0000, 16'h1357, 0,    0, 1, 3'b100, 23'h000008, 2'b00, 5,   16'h1357, 0);
    vecs[4]  = mk(24'h200000, 2'b11, 16'h1111, 16'h0000, 1000, 0, 1, 3'b001, 23'h100000, 2'b00, 4,   16'h1357, 0);
    vecs[5]  = mk(24'h200002, 2'b00, 16'h0000, 16'h2468, 0,    0, 1, 3'b001, 23'h100001, 2'b00, 4,   16'h2468, 0);
    vecs[6]  = mk(24'h004000, 2'b10, 16'hABCD, 16'h0000, 2,    0, 1, 3'b010, 23'h002000, 2'b10, 4,   16'h2468, 0);
    vecs[7]  = mk(24'h001000, 2'b00, 16'h0000, 16'h0000, 1000, 0, 1, 3'b010, 23'h000800, 2'b00, 258, 16'hFFFF, 1);
    vecs[8]  = mk(24'h001002, 2'b00, 16'h0000, 16'h5555, 0,    0, 1, 3'b010, 23'h000801, 2'b00, 3,   16'h5555, 1);
    vecs[9]  = mk(24'h200010, 2'b00, 16'h0000, 16'h9ABC, 3,    1, 1, 3'b001, 23'h100008, 2'b00, 5,   16'h9ABC, 1);
    vecs[10] = mk(24'h0000FF, 2'b00, 16'h0000, 16'h0102, 0,    0, 1, 3'b100, 23'h00007F, 2'b00, 5,   16'h0102, 1);
    vecs[11] = mk(24'h1FFFFE, 2'b00, 16'h0000, 16'h0304, 0,    0, 1, 3'b010, 23'h0FFFFF, 2'b00, 3,   16'h0304, 1);
    vecs[12] = mk(24'h000100, 2'b00, 16'h0000, 16'h0506, 0,    0, 1, 3'b010, 23'h000080, 2'b00, 3,   16'h0506, 1);

    rst = 1'b1; cen = 1'b1; ram_addr = '0; ram_din = '0; ram_we = '0;
    bus_din = '0; bus_ok = 1'b1;
    #1;
    chk("rst_cpu_cen", 32'(cpu_cen), 0);
    chk("rst_ram_dout", 32'(ram_dout), 0);
    chk("rst_bus_addr", 32'(bus_addr), 0);
    chk("rst_bus_cs", 32'(bus_cs), 0);
    chk("rst_bus_we", 32'(bus_we), 0);
    chk("rst_bus_err", 32'(bus_err), 0);
    cen = 1'b0;
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);

    // Reset asserted while an IO read sits in its wait states
    @(posedge clk); #1;
    ram_addr = 24'h000020; ram_we = 2'b00; cen = 1'b1; bus_ok = 1'b0;
    @(posedge clk); #1;
    chk("midrst_cs_before", 32'(bus_cs), 32'(3'b100));
    chk("midrst_addr_before", 32'(bus_addr), 32'h10);
    rst = 1'b1; #1;
    chk("midrst_cs", 32'(bus_cs), 0);
    chk("midrst_addr", 32'(bus_addr), 0);
    chk("midrst_dout", 32'(bus_dout), 0);
    chk("midrst_we", 32'(bus_we), 0);
    chk("midrst_ram_dout", 32'(ram_dout), 0);
    chk("midrst_err", 32'(bus_err), 0);
    cen = 1'b0; #1; rst = 1'b0;

    // After reset the held word is invalid, so a repeat address refetches
    run_vec(13, mk(24'h001002, 2'b00, 16'h0000, 16'h7777, 0, 0, 1, 3'b010,
                   23'h000801, 2'b00, 3, 16'h7777, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
